// File: rtl/anim_pkg.sv
// Shared types and default constants for the idle-animation sequencer.
package anim_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } mode_t;

  localparam int SPEED_MAX_DEF = 10;
  localparam int DWELL_DEF     = 64;
  localparam int SPEED_W       = 4;
  // Step counter must hold 2*speed+1, i.e. one bit wider than speed.
  localparam int STEP_W        = SPEED_W + 1;

endpackage

// File: rtl/anim_sequencer_if.sv
// Button inputs and display-control outputs of the animation sequencer.
interface anim_sequencer_if
  import anim_pkg::*;
#(
  parameter int NPAT = 8
);

  localparam int PW = (NPAT > 1) ? $clog2(NPAT) : 1;

  logic [NPAT-1:0]    sel;
  logic               btn_faster;
  logic               btn_slower;
  logic               btn_auto;
  logic               btn_pause;
  logic [PW-1:0]      pattern;
  logic [SPEED_W-1:0] speed;
  logic [1:0]         mode;
  logic               step;
  logic               restart;

  modport master (
    output sel, btn_faster, btn_slower, btn_auto, btn_pause,
    input  pattern, speed, mode, step, restart
  );

  modport slave (
    input  sel, btn_faster, btn_slower, btn_auto, btn_pause,
    output pattern, speed, mode, step, restart
  );

endinterface

// File: rtl/anim_sequencer_btn_edge.sv
// Registers a vector of raw button levels and flags rising edges.
// The copies reset to ones so a button held through reset stays silent.
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/anim_sequencer.sv
// Idle-animation controller: button decoding, mode FSM, step and dwell
// timing, and the step/restart strobes for the pattern ring counters.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int NPAT      = 8,
  parameter int SPEED_MAX = SPEED_MAX_DEF,
  parameter int DWELL     = DWELL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  anim_sequencer_if.slave bus
);

  localparam int PW = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int DW = $clog2(DWELL + 1);
  localparam int BW = NPAT + 4;

  mode_t              mode_q, mode_d;
  mode_t              savedMode_q, savedMode_d;
  logic [PW-1:0]      pattern_q, pattern_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [STEP_W-1:0]  stepCnt_q, stepCnt_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic               step_q, step_d;
  logic               restart_q, restart_d;

  logic [BW-1:0] rise;
  logic          pauseEdge, autoEdge, selEdge, fasterEdge, slowerEdge;
  logic          selValid;
  logic [PW-1:0] selIdx;
  logic          doRestart, clearStep, autoAct;

  btn_edge #(.W(BW)) u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  ({bus.sel, bus.btn_pause, bus.btn_auto, bus.btn_faster, bus.btn_slower}),
    .rise_o (rise)
  );

  assign slowerEdge = rise[0];
  assign fasterEdge = rise[1];
  assign autoEdge   = rise[2];
  assign pauseEdge  = rise[3];
  assign selEdge    = |rise[BW-1:4];
  assign selValid   = $onehot(bus.sel);

  always_comb begin
    selIdx = '0;
    for (int i = 0; i < NPAT; i++) begin
      if (bus.sel[i]) selIdx = PW'(i);
    end
  end

  // One button action per cycle in priority order, then the step/dwell timing.
  // Dwell is not counted on the cycle an auto press clears it.
  always_comb begin
    mode_d      = mode_q;
    savedMode_d = savedMode_q;
    pattern_d   = pattern_q;
    speed_d     = speed_q;
    stepCnt_d   = stepCnt_q;
    dwell_d     = dwell_q;
    step_d      = 1'b0;
    restart_d   = 1'b0;
    doRestart   = 1'b0;
    clearStep   = 1'b0;
    autoAct     = 1'b0;

    if (pauseEdge) begin
      if (mode_q == PAUSE) begin
        mode_d = savedMode_q;
      end else begin
        savedMode_d = mode_q;
        mode_d      = PAUSE;
      end
    end else if (autoEdge) begin
      autoAct = 1'b1;
      dwell_d = '0;
      case (mode_q)
        MANUAL:  mode_d = AUTO;
        AUTO:    mode_d = MANUAL;
        default: savedMode_d = (savedMode_q == AUTO) ? MANUAL : AUTO;
      endcase
    end else if (selEdge) begin
      if (selValid) begin
        pattern_d = selIdx;
        doRestart = 1'b1;
        if (mode_q == PAUSE) savedMode_d = MANUAL;
        else                 mode_d      = MANUAL;
      end
    end else if (fasterEdge) begin
      if (speed_q != '0) begin
        speed_d   = speed_q - 1'b1;
        clearStep = 1'b1;
      end
    end else if (slowerEdge) begin
      if (speed_q < SPEED_W'(SPEED_MAX)) begin
        speed_d   = speed_q + 1'b1;
        clearStep = 1'b1;
      end
    end

    if (doRestart) begin
      stepCnt_d = '0;
      dwell_d   = '0;
      restart_d = 1'b1;
    end else if (clearStep) begin
      stepCnt_d = '0;
    end else if (mode_d != PAUSE) begin
      if (stepCnt_q == {speed_q, 1'b1}) begin
        stepCnt_d = '0;
        if (mode_d == AUTO && !autoAct && dwell_q == DW'(DWELL)) begin
          restart_d = 1'b1;
          dwell_d   = '0;
          pattern_d = (pattern_q == PW'(NPAT - 1)) ? '0 : pattern_q + 1'b1;
        end else begin
          step_d = 1'b1;
          if (mode_d == AUTO && !autoAct) dwell_d = dwell_q + 1'b1;
        end
      end else begin
        stepCnt_d = stepCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MANUAL;
      savedMode_q <= MANUAL;
      pattern_q   <= '0;
      speed_q     <= SPEED_W'(1);
      stepCnt_q   <= '0;
      dwell_q     <= '0;
      step_q      <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      savedMode_q <= savedMode_d;
      pattern_q   <= pattern_d;
      speed_q     <= speed_d;
      stepCnt_q   <= stepCnt_d;
      dwell_q     <= dwell_d;
      step_q      <= step_d;
      restart_q   <= restart_d;
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.speed   = speed_q;
  assign bus.mode    = mode_q;
  assign bus.step    = step_q;
  assign bus.restart = restart_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed scenarios plus random
// button traffic, all compared against a cycle-level behavioural model.
module tb_anim_sequencer;

  localparam int NPAT      = 8;
  localparam int SPEED_MAX = 10;
  localparam int DWELL     = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int compared = 0;
  int mismatched = 0;

  anim_sequencer_if #(.NPAT(NPAT)) bus ();

  anim_sequencer #(.NPAT(NPAT), .SPEED_MAX(SPEED_MAX), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: mode 0=manual 1=auto 2=pause; elapsed counts cycles into the step interval.
  int mPattern, mSpeed, mMode, mSaved, mStep, mRestart, mElapsed, mSteps;
  logic [7:0] pSel;
  logic pF, pS, pA, pP;

  function automatic void modelReset();
    mPattern = 0; mSpeed = 1; mMode = 0; mSaved = 0;
    mStep = 0; mRestart = 0; mElapsed = 0; mSteps = 0;
    pSel = 8'hFF; pF = 1'b1; pS = 1'b1; pA = 1'b1; pP = 1'b1;
  endfunction

  function automatic void modelEdge(input logic [7:0] s, input logic f, input logic sl,
                                    input logic a, input logic p);
    logic [7:0] selRise;
    logic fR, sR, aR, pR;
    bit restartNow, cleared, autoPressed;
    selRise = s & ~pSel;
    fR = f & ~pF; sR = sl & ~pS; aR = a & ~pA; pR = p & ~pP;
    pSel = s; pF = f; pS = sl; pA = a; pP = p;
    mStep = 0; mRestart = 0;
    restartNow = 0; cleared = 0; autoPressed = 0;
    if (pR) begin
      if (mMode == 2) mMode = mSaved;
      else begin mSaved = mMode; mMode = 2; end
    end else if (aR) begin
      autoPressed = 1; mSteps = 0;
      if (mMode == 0) mMode = 1;
      else if (mMode == 1) mMode = 0;
      else mSaved = 1 - mSaved;
    end else if (selRise != 8'h00) begin
      if ($countones(s) == 1) begin
        mPattern = $clog2(s);
        restartNow = 1;
        if (mMode == 2) mSaved = 0; else mMode = 0;
      end
    end else if (fR) begin
      if (mSpeed > 0) begin mSpeed--; cleared = 1; end
    end else if (sR) begin
      if (mSpeed < SPEED_MAX) begin mSpeed++; cleared = 1; end
    end
    if (restartNow) begin
      mRestart = 1; mElapsed = 0; mSteps = 0;
    end else if (cleared) begin
      mElapsed = 0;
    end else if (mMode != 2) begin
      mElapsed++;
      if (mElapsed == 2 * mSpeed + 2) begin
        mElapsed = 0;
        if (mMode == 1 && !autoPressed && mSteps == DWELL) begin
          mRestart = 1; mSteps = 0; mPattern = (mPattern + 1) % NPAT;
        end else begin
          mStep = 1;
          if (mMode == 1 && !autoPressed) mSteps++;
        end
      end
    end
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkOutput();
    checkVal("pattern", 32'(bus.pattern), mPattern);
    checkVal("speed",   32'(bus.speed),   mSpeed);
    checkVal("mode",    32'(bus.mode),    mMode);
    checkVal("step",    32'(bus.step),    mStep);
    checkVal("restart", 32'(bus.restart), mRestart);
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic f, input logic sl,
                               input logic a, input logic p);
    bus.sel = s; bus.btn_faster = f; bus.btn_slower = sl; bus.btn_auto = a; bus.btn_pause = p;
    @(posedge clk);
    modelEdge(s, f, sl, a, p);
    #1;
    checkOutput();
  endtask

  task automatic waitStep(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      if (bus.step === 1'b1) break;
    end
  endtask

  task automatic waitRestart(input int start, input int limit, output int n);
    n = start;
    while (n < limit) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      if (bus.restart === 1'b1) break;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int sawStep;
    int r;
    logic [7:0] rs;

    // Reset with the auto button held down.
    bus.sel = 8'h00; bus.btn_faster = 1'b0; bus.btn_slower = 1'b0;
    bus.btn_auto = 1'b1; bus.btn_pause = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstPattern", 32'(bus.pattern), 0);
    checkVal("rstSpeed",   32'(bus.speed),   1);
    checkVal("rstMode",    32'(bus.mode),    0);
    checkVal("rstStep",    32'(bus.step),    0);
    checkVal("rstRestart", 32'(bus.restart), 0);
    rst_n = 1'b1;
    repeat (3) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("heldAutoMode", 32'(bus.mode), 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("autoMode", 32'(bus.mode), 1);

    // Valid one-hot select, then an invalid two-hot select.
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("selPattern", 32'(bus.pattern), 2);
    checkVal("selRestart", 32'(bus.restart), 1);
    checkVal("selMode",    32'(bus.mode),    0);
    waitStep(20, n);
    checkVal("selFirstStep", n, 4);
    applyStimulus(8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("badSelPattern", 32'(bus.pattern), 2);
    checkVal("badSelRestart", 32'(bus.restart), 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Speed changes and saturation at zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < 2) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkVal("slowSpeed", 32'(bus.speed), 4);
    waitStep(40, n);
    checkVal("slowFirst", n, 10);
    waitStep(40, n);
    checkVal("slowInterval", n, 10);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 11) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkVal("fastSpeed", 32'(bus.speed), 0);
    waitStep(10, n);
    checkVal("fastGap1", n, 2);
    waitStep(10, n);
    checkVal("fastGap2", n, 2);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("backToSpeed1", 32'(bus.speed), 1);

    // Auto-cycle: 7 wraps to 0, then 0 advances to 1.
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("sel7Pattern", 32'(bus.pattern), 7);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("autoAgain", 32'(bus.mode), 1);
    waitRestart(1, 300, n);
    checkVal("dwellWrapGap", n, 260);
    checkVal("wrapPattern", 32'(bus.pattern), 0);
    waitRestart(0, 300, n);
    checkVal("dwellGap", n, 260);
    checkVal("advPattern", 32'(bus.pattern), 1);

    // Pause mid-interval freezes the step counter.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("pauseMode", 32'(bus.mode), 2);
    sawStep = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.step !== 1'b0) sawStep = 1;
    end
    checkVal("pauseNoStep", sawStep, 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("resumeMode", 32'(bus.mode), 1);
    waitStep(10, n);
    checkVal("resumeRemain", n, 1);

    // Pause and select on the same edge: only pause acts.
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("prioMode",    32'(bus.mode),    2);
    checkVal("prioPattern", 32'(bus.pattern), 1);
    checkVal("prioRestart", 32'(bus.restart), 0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges.
    repeat (5) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("asyncPattern", 32'(bus.pattern), 0);
    checkVal("asyncMode",    32'(bus.mode),    0);
    checkVal("asyncRestart", 32'(bus.restart), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    waitStep(10, n);
    checkVal("postResetStep", n, 4);

    // Random button traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      rs = 8'h01 << $urandom_range(0, 7);
      else if (r == 1) rs = 8'($urandom);
      else             rs = 8'h00;
      applyStimulus(rs, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
